// File: rtl/dmux_pkg.sv
// Shared types and default sizing for the n-way stream demultiplexer.
package dmux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/dmux_slot.sv
// One-entry output slot of the demultiplexer.
// state      | meaning
// SLOT_EMPTY | no word held; out_data keeps the last loaded value
// SLOT_FULL  | word presented downstream, held until out_ready
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  slot_state_t state;

  // A full slot counts as free when it drains in the same cycle.
  assign free      = (state == SLOT_EMPTY) || out_ready;
  assign out_valid = (state == SLOT_FULL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else if (load) begin
      state    <= SLOT_FULL;
      out_data <= load_data;
    end else if (state == SLOT_FULL && out_ready) begin
      state <= SLOT_EMPTY;
    end
  end

endmodule

// File: rtl/dmux_n_way_stream.sv
// Valid/ready demultiplexer: routes each word to one channel slot, or to all
// slots at once on broadcast; flags words addressed to nonexistent channels.
module dmux_n_way_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      err_sel
);

  logic [CHANNELS-1:0] slot_free;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] slot_load;
  logic                sel_in_range;
  logic                accept;

  // Extra bit keeps the range compare meaningful when CHANNELS is a power of two.
  assign sel_in_range = {1'b0, in_sel} < (SEL_W+1)'(CHANNELS);

  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_hit[i] = (in_sel == SEL_W'(i));
    end
  end

  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &slot_free;
    end else if (sel_in_range) begin
      in_ready = |(sel_hit & slot_free);
    end
  end

  assign accept    = in_valid && in_ready;
  assign slot_load = accept ? (in_bcast ? '1 : sel_hit) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sel <= 1'b0;
    end else if (accept && !in_bcast && !sel_in_range) begin
      err_sel <= 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
    dmux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (slot_load[i]),
      .load_data(in_data),
      .out_ready(out_ready[i]),
      .free     (slot_free[i]),
      .out_valid(out_valid[i]),
      .out_data (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_dmux_n_way_stream.sv
// Self-checking bench for dmux_n_way_stream: directed cases plus a
// scoreboarded round-robin stream with random downstream backpressure.
module tb_dmux_n_way_stream;

  localparam int W  = 16;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset_n;

  logic          in_valid, in_ready, in_bcast, err_sel;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic [CH-1:0] out_valid, out_ready;
  logic [CH*W-1:0] out_data;

  logic          v3, rdy3, b3, err3;
  logic [W-1:0]  d3;
  logic [1:0]    s3;
  logic [2:0]    ov3, or3;
  logic [3*W-1:0] od3;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] sb_q [CH][$];
  int           rcv_cnt [CH];

  always #5 clk = ~clk;

  dmux_n_way_stream #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel)
  );

  dmux_n_way_stream #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .in_sel(s3), .in_bcast(b3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .err_sel(err3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ch_data(input int ch);
    return out_data[ch*W +: W];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_bcast = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    v3 = 1'b0; b3 = 1'b0; s3 = '0; d3 = '0; or3 = '0;
    for (int i = 0; i < CH; i++) rcv_cnt[i] = 0;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_sel", err_sel, 0);
    chk("rst_err_sel3", err3, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // single word to channel 2
    next_cycle();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 16'hBEEF;
    @(negedge clk);
    chk("load_ready", in_ready, 1);
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 4'b0100);
      chk("hold_data", ch_data(2), 16'hBEEF);
    end

    // full slot blocks, then drain+refill on the same edge
    next_cycle();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 16'hCAFE;
    @(negedge clk);
    chk("full_block_ready", in_ready, 0);
    next_cycle();
    @(negedge clk);
    chk("full_block_data", ch_data(2), 16'hBEEF);
    out_ready = 4'b0100;
    #1;
    chk("drain_refill_ready", in_ready, 1);
    next_cycle();
    in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    chk("refill_valid", out_valid, 4'b0100);
    chk("refill_data", ch_data(2), 16'hCAFE);
    out_ready = 4'b0100;
    next_cycle();
    out_ready = '0;
    @(negedge clk);
    chk("drain_empty", out_valid, 0);
    chk("empty_keeps_data", ch_data(2), 16'hCAFE);

    // broadcast blocked by one full slot, then loads all at once
    next_cycle();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h1111;
    next_cycle();
    in_bcast = 1'b1; in_sel = 2'd3; in_data = 16'h1234;
    @(negedge clk);
    chk("bcast_block_ready", in_ready, 0);
    next_cycle();
    @(negedge clk);
    chk("bcast_no_partial", out_valid, 4'b0010);
    chk("bcast_hold_ch1", ch_data(1), 16'h1111);
    out_ready = 4'b0010;
    #1;
    chk("bcast_ready", in_ready, 1);
    next_cycle();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
    @(negedge clk);
    chk("bcast_valid", out_valid, 4'b1111);
    for (int i = 0; i < CH; i++) chk($sformatf("bcast_data%0d", i), ch_data(i), 16'h1234);
    out_ready = 4'hF;
    next_cycle();
    out_ready = '0;

    // round-robin stream with random backpressure, scoreboarded
    begin
      int sent = 0;
      int cycles = 0;
      bit busy = 1'b1;
      while (busy && cycles < 300) begin
        in_valid = (sent < 8);
        in_sel = 2'(sent % 4);
        in_data = 16'h0100 + 16'(sent);
        out_ready = 4'($urandom_range(0, 15));
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
          chk($sformatf("stream_valid%0d", i), out_valid[i], sb_q[i].size() > 0);
          if (out_valid[i] && out_ready[i] && sb_q[i].size() > 0) begin
            chk($sformatf("stream_data%0d", i), ch_data(i), sb_q[i].pop_front());
            rcv_cnt[i]++;
          end
        end
        if (in_valid) begin
          chk("stream_ready", in_ready, (sb_q[in_sel].size() == 0) || out_ready[in_sel]);
          if (in_ready) begin
            sb_q[in_sel].push_back(in_data);
            sent++;
          end
        end
        next_cycle();
        cycles++;
        busy = (sent < 8);
        for (int i = 0; i < CH; i++) if (sb_q[i].size() > 0) busy = 1'b1;
      end
      in_valid = 1'b0; out_ready = '0;
      chk("stream_timeout", cycles >= 300, 0);
      for (int i = 0; i < CH; i++) chk($sformatf("stream_count%0d", i), rcv_cnt[i], 2);
    end

    // out-of-range select on the three-channel instance
    next_cycle();
    v3 = 1'b1; s3 = 2'd3; d3 = 16'h5555;
    @(negedge clk);
    chk("oor_ready", rdy3, 1);
    chk("oor_err_before", err3, 0);
    next_cycle();
    v3 = 1'b0;
    @(negedge clk);
    chk("oor_no_valid", ov3, 3'b000);
    chk("oor_err_set", err3, 1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("oor_err_sticky", err3, 1);
    chk("main_err_clear", err_sel, 0);

    // fill every slot, then reset asynchronously mid-cycle
    next_cycle();
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'hA5A5;
    next_cycle();
    in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 4'b1111);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_err3", err3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
